// File: rtl/mul_pkg.sv
// Shared encodings for the iterative radix-4 Booth multiplier: op codes,
// FSM states and Booth partial-product selects.
package mul_pkg;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        BS_ZERO = 3'd0,
        BS_POS1 = 3'd1,
        BS_POS2 = 3'd2,
        BS_NEG1 = 3'd3,
        BS_NEG2 = 3'd4
    } booth_sel_t;

    // Bits are {b[2i+1], b[2i], b[2i-1]} of the multiplier.
    function automatic booth_sel_t booth_decode(input logic [2:0] bits);
        booth_sel_t sel;
        case (bits)
            3'b001, 3'b010: sel = BS_POS1;
            3'b011:         sel = BS_POS2;
            3'b100:         sel = BS_NEG2;
            3'b101, 3'b110: sel = BS_NEG1;
            default:        sel = BS_ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mul_iter_unit_if.sv
// Request/response handshake bundle between the execute stage and the
// iterative multiplier.
interface mul_iter_unit_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output flush, in_valid, op, rs1, rs2, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  flush, in_valid, op, rs1, rs2, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: turns three multiplier bits into a two's-complement
// partial product of {0, +-1, +-2} times the multiplicand.
module booth_r4_enc
    import mul_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_bits,
    input  logic [XLEN+1:0] i_mcand,
    output logic [XLEN+3:0] o_pp
);

    booth_sel_t      w_sel;
    logic [XLEN+3:0] w_m1;
    logic [XLEN+3:0] w_m2;

    assign w_sel = booth_decode(i_bits);
    assign w_m1  = {{2{i_mcand[XLEN+1]}}, i_mcand};
    assign w_m2  = {i_mcand[XLEN+1], i_mcand, 1'b0};

    always_comb begin
        o_pp = '0;
        case (w_sel)
            BS_POS1: o_pp = w_m1;
            BS_POS2: o_pp = w_m2;
            BS_NEG1: o_pp = -w_m1;
            BS_NEG2: o_pp = -w_m2;
            default: o_pp = '0;
        endcase
    end

endmodule

// File: rtl/mul_iter_unit.sv
// Iterative radix-4 Booth multiplier for MUL/MULH/MULHSU/MULHU: one Booth
// step per cycle, fixed XLEN/2+1 step latency, valid/ready on both sides.
module mul_iter_unit
    import mul_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic          CLK,
    input  logic          rst_n,
    mul_iter_unit_if.slave bus
);

    localparam int ITER = XLEN / 2 + 1;
    localparam int CW   = $clog2(ITER);
    localparam int PW   = XLEN + 4;
    localparam int AW   = 2 * XLEN + 4;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_count;
    logic [1:0]      r_op;
    logic [XLEN+1:0] r_mcand;
    logic [XLEN+1:0] r_mplr;
    logic            r_prev;
    logic [AW-1:0]   r_acc;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [XLEN-1:0] r_result;

    logic            w_last;
    logic            w_accept;
    logic [XLEN+1:0] w_rs1_ext;
    logic [XLEN+1:0] w_rs2_ext;
    logic [PW-1:0]   w_pp;
    logic [AW-1:0]   w_acc_sum;
    logic [AW-1:0]   w_acc_nxt;

    assign w_last   = (r_count == CW'(ITER - 1));
    assign w_accept = r_in_ready && bus.in_valid && !bus.flush;

    assign w_rs1_ext = (bus.op == OP_MULHU) ? {2'b00, bus.rs1}
                                            : {{2{bus.rs1[XLEN-1]}}, bus.rs1};
    assign w_rs2_ext = (bus.op == OP_MULHSU || bus.op == OP_MULHU)
                     ? {2'b00, bus.rs2} : {{2{bus.rs2[XLEN-1]}}, bus.rs2};

    booth_r4_enc #(.XLEN(XLEN)) u_enc (
        .i_bits  ({r_mplr[1:0], r_prev}),
        .i_mcand (r_mcand),
        .o_pp    (w_pp)
    );

    // Partial product enters at bit XLEN+2 so that after ITER shifts of 2 the
    // first digit lands at bit 0; the running sum always fits in AW bits.
    assign w_acc_sum = r_acc + ({{XLEN{w_pp[PW-1]}}, w_pp} << (XLEN + 2));
    assign w_acc_nxt = {{2{w_acc_sum[AW-1]}}, w_acc_sum[AW-1:2]};

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid)  w_state_nxt = ST_BUSY;
            ST_BUSY: if (w_last)        w_state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
        if (bus.flush) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_count     <= '0;
            r_acc       <= '0;
            r_op        <= OP_MUL;
            r_mcand     <= '0;
            r_mplr      <= '0;
            r_prev      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_DONE);
            if (w_accept) begin
                r_op    <= bus.op;
                r_mcand <= w_rs1_ext;
                r_mplr  <= w_rs2_ext;
                r_prev  <= 1'b0;
                r_acc   <= '0;
                r_count <= '0;
            end else if (r_state == ST_BUSY) begin
                r_acc   <= w_acc_nxt;
                r_mplr  <= r_mplr >> 2;
                r_prev  <= r_mplr[1];
                r_count <= r_count + CW'(1);
                if (w_last && !bus.flush)
                    r_result <= (r_op == OP_MUL) ? w_acc_nxt[XLEN-1:0]
                                                 : w_acc_nxt[2*XLEN-1:XLEN];
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;

endmodule

// File: tb/tb_mul_iter_unit.sv
// Bench for mul_iter_unit: 64-bit arithmetic reference with a cycle-level
// timing model, per-cycle output compare, directed cases and random traffic.
module tb_mul_iter_unit;
    import mul_pkg::*;

    localparam int XLEN = 32;
    localparam int ITER = XLEN / 2 + 1;

    logic CLK   = 1'b0;
    logic rst_n = 1'b1;

    mul_iter_unit_if #(.XLEN(XLEN)) bus();

    mul_iter_unit #(.XLEN(XLEN)) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    int dut_hs   = 0;

    function automatic logic [31:0] gold(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (o == OP_MULHU) ? {32'b0, a} : {{32{a[31]}}, a};
        eb = (o == OP_MULHSU || o == OP_MULHU) ? {32'b0, b} : {{32{b[31]}}, b};
        p  = ea * eb;
        return (o == OP_MUL) ? p[31:0] : p[63:32];
    endfunction

    // Reference: an op accepted at edge k is presented from edge k+ITER until
    // the first later edge with out_ready; flush drops whatever is held.
    logic        m_have = 1'b0;
    int          m_edge = 0;
    int          m_tv   = 0;
    int          m_nacc = 0;
    int          m_nhs  = 0;
    logic [31:0] m_res  = '0;

    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            m_have <= 1'b0;
        end else begin
            m_edge <= m_edge + 1;
            if (bus.flush) begin
                m_have <= 1'b0;
            end else if (!m_have && bus.in_valid) begin
                m_have <= 1'b1;
                m_tv   <= m_edge + 1 + ITER;
                m_res  <= gold(bus.op, bus.rs1, bus.rs2);
                m_nacc <= m_nacc + 1;
            end else if (m_have && (m_edge + 1 > m_tv) && bus.out_ready) begin
                m_have <= 1'b0;
                m_nhs  <= m_nhs + 1;
            end
        end
    end

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    task automatic monitor();
        logic ev;
        forever begin
            @(negedge CLK);
            if (rst_n) begin
                ev = m_have && (m_edge >= m_tv);
                chk1("in_ready", bus.in_ready, !m_have);
                chk1("out_valid", bus.out_valid, ev);
                if (ev) chk32("result", bus.result, m_res);
                if (bus.out_valid && bus.out_ready && !bus.flush) dut_hs++;
            end
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 100; i++) begin
            if (bus.in_ready) return;
            @(posedge CLK); #1;
        end
        timeout("wait_in_ready");
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int hold);
        int lat;
        wait_ready();
        bus.in_valid = 1'b1; bus.op = o; bus.rs1 = a; bus.rs2 = b; bus.out_ready = 1'b0;
        @(posedge CLK); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            chk1("in_ready_busy", bus.in_ready, 1'b0);
            @(posedge CLK); #1;
            lat++;
        end
        chk32("latency", 32'(lat), 32'(ITER));
        for (int h = 0; h < hold; h++) begin
            chk1("hold_valid", bus.out_valid, 1'b1);
            chk32("hold_result", bus.result, exp);
            chk1("hold_in_ready", bus.in_ready, 1'b0);
            @(posedge CLK); #1;
        end
        chk32("op_result", bus.result, exp);
        bus.out_ready = 1'b1;
        @(posedge CLK); #1;
        bus.out_ready = 1'b0;
        chk1("post_hs_in_ready", bus.in_ready, 1'b1);
        chk1("post_hs_out_valid", bus.out_valid, 1'b0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int base, hs0, dhs0, cyc;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.op = OP_MUL;
        bus.rs1 = '0; bus.rs2 = '0; bus.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk1("reset_in_ready", bus.in_ready, 1'b1);
        chk1("reset_out_valid", bus.out_valid, 1'b0);
        chk32("reset_result", bus.result, 32'h0);
        repeat (3) @(posedge CLK);
        #1 rst_n = 1'b1;
        fork monitor(); join_none

        do_op(OP_MUL,    32'h8000_0000, 32'h8000_0001, 32'h8000_0000, 0);
        do_op(OP_MULH,   32'h8000_0000, 32'h8000_0001, 32'h3FFF_FFFF, 0);
        do_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        do_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0);
        do_op(OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        do_op(OP_MUL,    32'd10,        32'd6,         32'h0000_003C, 5);

        // Flush after eight Booth steps.
        wait_ready();
        bus.in_valid = 1'b1; bus.op = OP_MUL; bus.rs1 = 32'd1234; bus.rs2 = 32'd5678;
        @(posedge CLK); #1;
        bus.in_valid = 1'b0;
        repeat (8) @(posedge CLK);
        #1 bus.flush = 1'b1;
        @(posedge CLK); #1;
        bus.flush = 1'b0;
        chk1("flush_in_ready", bus.in_ready, 1'b1);
        chk1("flush_out_valid", bus.out_valid, 1'b0);
        repeat (20) @(posedge CLK);
        #1;
        chk1("flush_no_pulse", bus.out_valid, 1'b0);
        do_op(OP_MUL, 32'd5, 32'd70, 32'h0000_015E, 0);

        // Asynchronous reset in the middle of BUSY.
        wait_ready();
        bus.in_valid = 1'b1; bus.op = OP_MULH; bus.rs1 = 32'h1234_5678; bus.rs2 = 32'h9ABC_DEF0;
        @(posedge CLK); #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge CLK);
        #3 rst_n = 1'b0;
        #1;
        chk1("midrst_in_ready", bus.in_ready, 1'b1);
        chk1("midrst_out_valid", bus.out_valid, 1'b0);
        chk32("midrst_result", bus.result, 32'h0);
        @(posedge CLK); #1 rst_n = 1'b1;

        // Back-to-back with in_valid and out_ready held high.
        base = m_nacc; hs0 = m_nhs; dhs0 = dut_hs;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        cyc = 0;
        while (m_nacc - base < 4 && cyc < 200) begin
            bus.op = 2'($urandom_range(0, 3)); bus.rs1 = pick(); bus.rs2 = pick();
            @(posedge CLK); #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        cyc = 0;
        while (m_have && cyc < 50) begin @(posedge CLK); #1; cyc++; end
        if (m_have) timeout("b2b_drain");
        bus.out_ready = 1'b0;
        chk32("b2b_model_hs", 32'(m_nhs - hs0), 32'd4);
        chk32("b2b_dut_hs", 32'(dut_hs - dhs0), 32'd4);

        // Random traffic with occasional flush and backpressure.
        base = m_nacc;
        cyc = 0;
        while (m_nacc - base < 200 && cyc < 20000) begin
            bus.flush     = ($urandom_range(0, 49) == 0);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.op        = 2'($urandom_range(0, 3));
            bus.rs1       = pick();
            bus.rs2       = pick();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge CLK); #1;
            cyc++;
        end
        if (m_nacc - base < 200) timeout("random_accepts");
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        cyc = 0;
        while (m_have && cyc < 50) begin @(posedge CLK); #1; cyc++; end
        if (m_have) timeout("random_drain");
        @(posedge CLK); #1;
        chk32("total_handshakes", 32'(dut_hs), 32'(m_nhs));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
